// File: rtl/mdu_exec_ctrl_if.sv
// Issue/strobe/writeback bundle between the MDU issue unit, the sequencing
// controller and the multiply/divide datapath.
interface mdu_exec_ctrl_if #(
    parameter int TAG_W = 6
);
    logic             flush;
    logic             issue_en;
    logic             issue_is_mul;
    logic [TAG_W-1:0] issue_tag;
    logic             issue_div0;
    logic             mul_start;
    logic             div_start;
    logic             mul_advance;
    logic             mul_busy;
    logic             div_busy;
    logic             wb_valid;
    logic             wb_sel;
    logic [TAG_W-1:0] wb_tag;
    logic             wb_ready;

    modport slave (
        input  flush, issue_en, issue_is_mul, issue_tag, issue_div0, wb_ready,
        output mul_start, div_start, mul_advance, mul_busy, div_busy,
               wb_valid, wb_sel, wb_tag
    );

    modport master (
        output flush, issue_en, issue_is_mul, issue_tag, issue_div0, wb_ready,
        input  mul_start, div_start, mul_advance, mul_busy, div_busy,
               wb_valid, wb_sel, wb_tag
    );
endinterface

// File: rtl/mdu_exec_ctrl.sv
// MDU sequencing controller: multiplier pipe tracking, divider FSM and
// div-over-mul writeback arbitration. Optional: MDU_DIV_ZERO_FAST_EN.
module mdu_exec_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32,
    parameter int TAG_W   = 6
) (
    input  logic            clk,
    input  logic            rst,
    mdu_exec_ctrl_if.slave  bus
);
    localparam int CNT_W = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] dtag_q, dtag_d;

    logic [MUL_LAT-1:0] mv_q;
    logic [TAG_W-1:0]   mt_q [MUL_LAT];

    logic kill;
    logic last_valid;
    logic div_req;
    logic mul_stall;
    logic mul_start;
    logic div_start;
    logic div_busy;
    logic div0_fast;

    // Reset and flush share one clearing path, including gating the strobes.
    assign kill       = rst | bus.flush;
    assign last_valid = mv_q[MUL_LAT-1];
    assign div_req    = (state_q == DIV_DONE);
    assign div_busy   = (state_q != DIV_IDLE);
    assign mul_stall  = last_valid & ~(bus.wb_ready & ~div_req);

    assign mul_start = bus.issue_en & bus.issue_is_mul & ~mul_stall & ~kill;
    assign div_start = bus.issue_en & ~bus.issue_is_mul & ~div_busy & ~kill;

`ifdef MDU_DIV_ZERO_FAST_EN
    assign div0_fast = bus.issue_div0;
`else
    logic unused_div0;
    assign unused_div0 = bus.issue_div0;
    assign div0_fast   = 1'b0;
`endif

    assign bus.mul_start   = mul_start;
    assign bus.div_start   = div_start;
    assign bus.mul_advance = ~mul_stall;
    assign bus.mul_busy    = mul_stall;
    assign bus.div_busy    = div_busy;
    assign bus.wb_valid    = ~kill & (div_req | last_valid);
    assign bus.wb_sel      = div_req;
    assign bus.wb_tag      = div_req ? dtag_q : mt_q[MUL_LAT-1];

    // The whole pipe advances or holds as one; bubbles are never squeezed out.
    genvar gi;
    generate
        for (gi = 0; gi < MUL_LAT; gi++) begin : g_stage
            logic             in_v;
            logic [TAG_W-1:0] in_t;
            if (gi == 0) begin : g_head
                assign in_v = mul_start;
                assign in_t = bus.issue_tag;
            end else begin : g_body
                assign in_v = mv_q[gi-1];
                assign in_t = mt_q[gi-1];
            end
            always_ff @(posedge clk) begin
                if (kill) begin
                    mv_q[gi] <= 1'b0;
                    mt_q[gi] <= '0;
                end else if (!mul_stall) begin
                    mv_q[gi] <= in_v;
                    mt_q[gi] <= in_t;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (kill) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            dtag_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dtag_q  <= dtag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dtag_d  = dtag_q;
        case (state_q)
            DIV_IDLE: begin
                if (div_start) begin
                    dtag_d  = bus.issue_tag;
                    cnt_d   = CNT_INIT;
                    state_d = div0_fast ? DIV_DONE : DIV_RUN;
                end
            end
            DIV_RUN: begin
                if (cnt_q == '0) begin
                    state_d = DIV_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV_DONE: begin
                if (bus.wb_ready) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mdu_exec_ctrl.sv
// Randomized scoreboard bench for mdu_exec_ctrl against a uop-level model of
// pipe positions and divider countdowns.
module tb_mdu_exec_ctrl;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 32;
    localparam int TAG_W   = 6;
    localparam int NCYC    = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdu_exec_ctrl_if #(.TAG_W(TAG_W)) bus ();

    mdu_exec_ctrl #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .TAG_W   (TAG_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int             cyc;
        bit             mul_start;
        bit             div_start;
        bit             mul_advance;
        bit             mul_busy;
        bit             div_busy;
        bit             wb_valid;
        bit             wb_sel;
        bit [TAG_W-1:0] wb_tag;
    } exp_t;

    typedef struct {
        int             pos;
        bit [TAG_W-1:0] tag;
    } mul_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   drv_done = 1'b0;

    // Model state: mults by pipe position, one div as a countdown to its request.
    mul_t           mq[$];
    bit             d_active = 1'b0;
    int             d_wait   = 0;
    bit [TAG_W-1:0] d_tag    = '0;

    function automatic void chk(string name, int cyc, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endfunction

    initial begin
        bus.flush        = 1'b0;
        bus.issue_en     = 1'b0;
        bus.issue_is_mul = 1'b0;
        bus.issue_tag    = '0;
        bus.issue_div0   = 1'b0;
        bus.wb_ready     = 1'b1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            bit             r, fl, en, im, d0, rdy;
            bit [TAG_W-1:0] tg;
            bit             kill, lv, dr, stall, ms, ds;
            exp_t           e;
            @(posedge clk);
            #1;
            r = (cyc < 3) || (cyc == 1500);
            fl = 1'b0; en = 1'b0; im = 1'b0; d0 = 1'b0; rdy = 1'b1; tg = '0;
            if (cyc < 80) begin
                // Directed opening: lone mult tag 5, then lone div tag 9, then a collision.
                if (cyc == 3)  begin en = 1'b1; im = 1'b1; tg = 6'd5; end
                if (cyc == 10) begin en = 1'b1; im = 1'b0; tg = 6'd9; end
                if (cyc == 47) begin en = 1'b1; im = 1'b0; tg = 6'd9; end
                if (cyc == 77) begin en = 1'b1; im = 1'b1; tg = 6'd4; end
            end else begin
                en  = ($urandom % 2) == 0;
                im  = ($urandom % 3) != 0;
                tg  = TAG_W'($urandom);
                d0  = ($urandom % 4) == 0;
                fl  = ($urandom % 70) == 0;
                rdy = (((cyc / 50) % 4) == 3) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            end
            rst              = r;
            bus.flush        = fl;
            bus.issue_en     = en;
            bus.issue_is_mul = im;
            bus.issue_tag    = tg;
            bus.issue_div0   = d0;
            bus.wb_ready     = rdy;

            kill  = r | fl;
            lv    = (mq.size() > 0) && (mq[0].pos == MUL_LAT);
            dr    = d_active && (d_wait == 0);
            stall = lv && !(rdy && !dr);
            ms    = en && im && !stall && !kill;
            ds    = en && !im && !d_active && !kill;
            e.cyc         = cyc;
            e.mul_start   = ms;
            e.div_start   = ds;
            e.mul_advance = !stall;
            e.mul_busy    = stall;
            e.div_busy    = d_active;
            e.wb_valid    = !kill && (dr || lv);
            e.wb_sel      = dr;
            e.wb_tag      = dr ? d_tag : (lv ? mq[0].tag : '0);
            exp_q.push_back(e);

            if (kill) begin
                mq.delete();
                d_active = 1'b0;
                d_wait   = 0;
            end else begin
                if (!stall) begin
                    if (lv) void'(mq.pop_front());
                    foreach (mq[i]) mq[i].pos++;
                    if (ms) mq.push_back('{pos: 1, tag: tg});
                end
                if (d_active) begin
                    if (d_wait > 0) d_wait--;
                    else if (rdy) d_active = 1'b0;
                end
                if (ds) begin
                    d_active = 1'b1;
                    d_tag    = tg;
`ifdef MDU_DIV_ZERO_FAST_EN
                    d_wait   = d0 ? 0 : DIV_LAT;
`else
                    d_wait   = DIV_LAT;
`endif
                end
            end
        end
        @(posedge clk);
        drv_done = 1'b1;
        repeat (2) @(posedge clk);
        chk("queue_drained", NCYC, 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    always @(negedge clk) begin
        if (!drv_done && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mul_start",   e.cyc, 32'(bus.mul_start),   32'(e.mul_start));
            chk("div_start",   e.cyc, 32'(bus.div_start),   32'(e.div_start));
            chk("mul_advance", e.cyc, 32'(bus.mul_advance), 32'(e.mul_advance));
            chk("mul_busy",    e.cyc, 32'(bus.mul_busy),    32'(e.mul_busy));
            chk("div_busy",    e.cyc, 32'(bus.div_busy),    32'(e.div_busy));
            chk("wb_valid",    e.cyc, 32'(bus.wb_valid),    32'(e.wb_valid));
            chk("wb_sel",      e.cyc, 32'(bus.wb_sel),      32'(e.wb_sel));
            if (e.wb_valid) begin
                chk("wb_tag", e.cyc, 32'(bus.wb_tag), 32'(e.wb_tag));
                if (bus.wb_ready)
                    $display("wb cyc=%0d sel=%0d tag=%0d", e.cyc, bus.wb_sel, bus.wb_tag);
            end
        end
    end
endmodule
